// File: rtl/sobel_edge_engine.sv
// rtl/sobel_edge_engine.sv - streaming 3x3 Sobel edge detector with clamped Gx/Gy and scaled magnitude
module sobel_edge_engine #(
    parameter int WIDTH     = 800,
    parameter int PRECISION = 12,
    parameter int THRESH    = 15,
    parameter int GAIN      = 24
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] pixel_in,
    input  logic       hs_in,
    input  logic       vs_in,
    input  logic       blank_n_in,
    output logic [7:0] gx_out,
    output logic [7:0] gy_out,
    output logic [7:0] edge_out,
    output logic       hs_out,
    output logic       vs_out,
    output logic       blank_n_out
);

    localparam int DEPTH = 2*WIDTH + 3;
    localparam int MW    = PRECISION + 1;
    localparam int PW    = MW + 32;
    localparam logic [MW-1:0] THRESH_M = MW'(THRESH);
    localparam logic [31:0]   GAIN_W   = 32'(GAIN);

    typedef logic signed [PRECISION-1:0] sval_t;

    function automatic sval_t ext(input logic [7:0] p);
        return sval_t'({{(PRECISION-8){1'b0}}, p});
    endfunction

    function automatic logic [7:0] clamp_s(input sval_t v);
        if (v < 0)
            return 8'd0;
        else if (v > sval_t'(255))
            return 8'hFF;
        else
            return v[7:0];
    endfunction

    // Tap 0 is the newest pixel; taps WIDTH and 2*WIDTH start the previous two lines.
    logic [7:0] tap_q [DEPTH];
    logic [7:0] tap_d [DEPTH];
    sval_t      w [3][3];

    sval_t      gx_q, gx_d, gy_q, gy_d;
    logic [7:0] gxo_q, gxo_d, gyo_q, gyo_d, edge_q, edge_d;
    logic [2:0] sb1_q, sb1_d, sb2_q, sb2_d, sb3_q, sb3_d;

    logic signed [MW-1:0] gx_x, gy_x;
    logic [MW-1:0]        gx_abs, gy_abs, mag;
    logic [PW-1:0]        prod, scaled;

    always_comb begin
        tap_d[0] = pixel_in;
        for (int i = 1; i < DEPTH; i++)
            tap_d[i] = tap_q[i-1];
    end

    always_comb begin
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[r][c] = ext(tap_q[(2-r)*WIDTH + (2-c)]);
    end

    always_comb begin
        gx_d = (w[0][2] + (w[1][2] <<< 1) + w[2][2]) - (w[0][0] + (w[1][0] <<< 1) + w[2][0]);
        gy_d = (w[0][0] + (w[0][1] <<< 1) + w[0][2]) - (w[2][0] + (w[2][1] <<< 1) + w[2][2]);
    end

    // Magnitude is widened by one bit so |Gx|+|Gy| cannot wrap before scaling.
    always_comb begin
        gx_x   = {gx_q[PRECISION-1], gx_q};
        gy_x   = {gy_q[PRECISION-1], gy_q};
        gx_abs = gx_x[MW-1] ? $unsigned(-gx_x) : $unsigned(gx_x);
        gy_abs = gy_x[MW-1] ? $unsigned(-gy_x) : $unsigned(gy_x);
        mag    = gx_abs + gy_abs;
        prod   = {32'b0, mag} * {{MW{1'b0}}, GAIN_W};
        scaled = prod >> 4;
        gxo_d  = clamp_s(gx_q);
        gyo_d  = clamp_s(gy_q);
        if (mag < THRESH_M)
            edge_d = 8'd0;
        else if (scaled > PW'(255))
            edge_d = 8'hFF;
        else
            edge_d = scaled[7:0];
    end

    always_comb begin
        sb1_d = {hs_in, vs_in, blank_n_in};
        sb2_d = sb1_q;
        sb3_d = sb2_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++)
                tap_q[i] <= '0;
            gx_q   <= '0;
            gy_q   <= '0;
            gxo_q  <= '0;
            gyo_q  <= '0;
            edge_q <= '0;
            sb1_q  <= '0;
            sb2_q  <= '0;
            sb3_q  <= '0;
        end else begin
            tap_q  <= tap_d;
            gx_q   <= gx_d;
            gy_q   <= gy_d;
            gxo_q  <= gxo_d;
            gyo_q  <= gyo_d;
            edge_q <= edge_d;
            sb1_q  <= sb1_d;
            sb2_q  <= sb2_d;
            sb3_q  <= sb3_d;
        end
    end

    assign gx_out      = gxo_q;
    assign gy_out      = gyo_q;
    assign edge_out    = edge_q;
    assign hs_out      = sb3_q[2];
    assign vs_out      = sb3_q[1];
    assign blank_n_out = sb3_q[0];

endmodule

// File: tb/tb_sobel_edge_engine.sv
// tb/tb_sobel_edge_engine.sv - self-checking bench for sobel_edge_engine with a pixel-history model
module tb_sobel_edge_engine;

    localparam int W  = 8;
    localparam int HL = 2*W + 5;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] pixel_in;
    logic       hs_in, vs_in, blank_n_in;
    logic [7:0] gx_out, gy_out, edge_out;
    logic       hs_out, vs_out, blank_n_out;

    sobel_edge_engine #(.WIDTH(W), .PRECISION(12), .THRESH(15), .GAIN(24)) dut (
        .clk(clk), .reset_n(reset_n), .pixel_in(pixel_in),
        .hs_in(hs_in), .vs_in(vs_in), .blank_n_in(blank_n_in),
        .gx_out(gx_out), .gy_out(gy_out), .edge_out(edge_out),
        .hs_out(hs_out), .vs_out(vs_out), .blank_n_out(blank_n_out)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // hp[0] is the pixel sampled at the latest edge; sbh likewise for the sideband triple.
    int         hp [HL];
    logic [2:0] sbh [3];

    bit track;
    int mx_gx, mx_gy, mx_ed, mn_gx;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clamp8(input int v);
        if (v < 0) return 0;
        if (v > 255) return 255;
        return v;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Outputs after edge n describe the window whose newest pixel arrived at edge n-2.
    function automatic int win(input int r, input int c);
        return hp[2 + (2-r)*W + (2-c)];
    endfunction

    task automatic model_update();
        if (!reset_n) begin
            for (int i = 0; i < HL; i++) hp[i] = 0;
            for (int i = 0; i < 3; i++) sbh[i] = 3'b000;
        end else begin
            for (int i = HL-1; i > 0; i--) hp[i] = hp[i-1];
            hp[0]  = int'(pixel_in);
            sbh[2] = sbh[1];
            sbh[1] = sbh[0];
            sbh[0] = {hs_in, vs_in, blank_n_in};
        end
    endtask

    task automatic model_check();
        int gx, gy, m, ed;
        gx = (win(0,2) + 2*win(1,2) + win(2,2)) - (win(0,0) + 2*win(1,0) + win(2,0));
        gy = (win(0,0) + 2*win(0,1) + win(0,2)) - (win(2,0) + 2*win(2,1) + win(2,2));
        m  = iabs(gx) + iabs(gy);
        ed = (m < 15) ? 0 : clamp8((m * 24) / 16);
        check("gx_out", int'(gx_out), clamp8(gx));
        check("gy_out", int'(gy_out), clamp8(gy));
        check("edge_out", int'(edge_out), ed);
        check("hs_out", int'(hs_out), int'(sbh[2][2]));
        check("vs_out", int'(vs_out), int'(sbh[2][1]));
        check("blank_n_out", int'(blank_n_out), int'(sbh[2][0]));
    endtask

    task automatic stat_reset();
        mx_gx = -1; mx_gy = -1; mx_ed = -1; mn_gx = 999;
    endtask

    task automatic drive(input int p, input logic h, input logic v, input logic b);
        pixel_in   = p[7:0];
        hs_in      = h;
        vs_in      = v;
        blank_n_in = b;
        @(posedge clk);
        model_update();
        #1;
        model_check();
        @(negedge clk);
        if (track) begin
            if (int'(gx_out) > mx_gx) mx_gx = int'(gx_out);
            if (int'(gx_out) < mn_gx) mn_gx = int'(gx_out);
            if (int'(gy_out) > mx_gy) mx_gy = int'(gy_out);
            if (int'(edge_out) > mx_ed) mx_ed = int'(edge_out);
        end
    endtask

    function automatic int pix(input int kind, input int idx);
        int col, line;
        col  = idx % W;
        line = idx / W;
        case (kind)
            0: return 100;
            1: return (col < 4) ? 0 : 200;
            2: return (col < 4) ? 200 : 0;
            4: return (line < 2) ? 50 : 0;
            5: return (line == 1 && col == 4) ? 7 : 0;
            6: return (line == 1 && col == 4) ? 8 : 0;
            7: return int'($urandom_range(255));
            default: return 0;
        endcase
    endfunction

    task automatic run(input int kind, input int nlines, input int track_from);
        for (int i = 0; i < nlines*W; i++) begin
            if (i == track_from) begin
                stat_reset();
                track = 1'b1;
            end
            if (kind == 7)
                drive(pix(kind, i), 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
            else
                drive(pix(kind, i), (i % W) == 3, (i / W) == 0, (i % W) < 6);
        end
        track = 1'b0;
    endtask

    initial begin
        int lat, wid;
        track      = 1'b0;
        reset_n    = 1'b0;
        pixel_in   = 8'd200;
        hs_in      = 1'b0;
        vs_in      = 1'b0;
        blank_n_in = 1'b0;
        stat_reset();
        @(negedge clk);
        repeat (3) drive(200, 1'b0, 1'b0, 1'b0);
        check("rst_gx", int'(gx_out), 0);
        check("rst_gy", int'(gy_out), 0);
        check("rst_edge", int'(edge_out), 0);

        reset_n = 1'b1;
        drive(200, 1'b0, 1'b0, 1'b1);
        check("rel1_edge", int'(edge_out), 0);
        drive(200, 1'b0, 1'b0, 1'b1);
        check("rel2_gx", int'(gx_out), 0);
        drive(200, 1'b0, 1'b0, 1'b1);
        check("rel3_gx", int'(gx_out), 200);
        check("rel3_edge", int'(edge_out), 255);

        run(0, 5, 24);
        check("flat_max_gx", mx_gx, 0);
        check("flat_max_gy", mx_gy, 0);
        check("flat_max_edge", mx_ed, 0);

        run(1, 5, 24);
        check("vstep_max_gx", mx_gx, 255);
        check("vstep_max_edge", mx_ed, 255);
        check("vstep_max_gy", mx_gy, 0);

        run(2, 5, 24);
        check("vrev_min_gx", mn_gx, 0);
        check("vrev_max_gy", mx_gy, 0);

        run(3, 3, -1);
        run(4, 6, 0);
        check("hstep_max_gy", mx_gy, 200);
        check("hstep_max_edge", mx_ed, 255);

        run(5, 5, 0);
        check("m14_max_edge", mx_ed, 0);
        check("m14_max_gx", mx_gx, 14);

        run(6, 5, 0);
        check("m16_max_edge", mx_ed, 24);

        run(3, 1, -1);
        lat = 0;
        wid = 0;
        for (int k = 0; k < 10; k++) begin
            drive(0, k < 2, 1'b0, 1'b1);
            if (hs_out) begin
                if (lat == 0) lat = k + 1;
                wid++;
            end
        end
        check("hs_latency", lat, 3);
        check("hs_width", wid, 2);

        run(7, 5, -1);
        reset_n = 1'b0;
        #1;
        check("midrst_gx", int'(gx_out), 0);
        check("midrst_gy", int'(gy_out), 0);
        check("midrst_edge", int'(edge_out), 0);
        check("midrst_sideband", int'({hs_out, vs_out, blank_n_out}), 0);
        drive(int'($urandom_range(255)), 1'b1, 1'b1, 1'b1);
        drive(int'($urandom_range(255)), 1'b1, 1'b1, 1'b1);
        reset_n = 1'b1;
        run(7, 4, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
